// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter (sends one command byte).
//
// Ports:
//   CLOCK_50    in   system clock (50 MHz)
//   reset_n     in   asynchronous active-low reset
//   tx_valid    in   request to send tx_data
//   tx_data     in   [7:0] command byte, sampled only at accept
//   tx_ready    out  high only when idle; accept = tx_valid & tx_ready
//   tx_busy     out  ~tx_ready
//   tx_done     out  1-cycle pulse: byte acked and bus back to idle
//   tx_error    out  1-cycle pulse: transfer aborted
//   err_code    out  [1:0] 01 start timeout, 10 bit timeout, 11 no ack
//   ps2_clk_in  in   raw PS2_CLK pin
//   ps2_dat_in  in   raw PS2_DAT pin
//   ps2_clk_oe  out  1 = drive PS2_CLK low
//   ps2_dat_oe  out  1 = drive PS2_DAT low
//
// Optional feature macro: PS2_TX_RETRY_EN -- a bit-timeout or missing-ack
// failure on the first attempt resends the latched frame once.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned SETUP_CYCLES   = 50,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_B = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] START_LIM = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] BIT_LIM   = CW'(BIT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [10:0]   frame_q, frame_d;
  logic [1:0]    err_q, err_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          fall;
  logic          fail;
  logic [1:0]    fail_code;
`ifdef PS2_TX_RETRY_EN
  logic          retry_q, retry_d;
`endif

  // Pin synchronizers; idle bus reads high.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '1;
      err_q    <= '0;
      ack_q    <= 1'b1;
      done_q   <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    err_d     = err_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    fail      = 1'b0;
    fail_code = 2'b00;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
          err_d   = '0;
          cnt_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        idx_d = '0;
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (fall) begin
          cnt_d = '0;
          if (idx_q == 4'd10) begin
            ack_d   = dat_sync_q;
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q == 4'd0) begin
          // idx still 0 means the device has not clocked since release.
          if (cnt_q >= START_LIM) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q >= BIT_LIM) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (!ack_q) begin
          state_d = S_WAIT_IDLE;
        end else begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q >= BIT_LIM) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      // Start timeouts are final; other failures get one silent resend.
      if (fail_code != 2'b01 && !retry_q) begin
        state_d = S_INHIBIT;
        cnt_d   = '0;
        retry_d = 1'b1;
      end else begin
        state_d = S_ERR;
        err_d   = fail_code;
      end
`else
      state_d = S_ERR;
      err_d   = fail_code;
`endif
    end

    // Pin drives are registered from next state so they are glitch-free and
    // the newly indexed bit appears the cycle after the edge is seen.
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    dat_oe_d = (state_d == S_REQ) || ((state_d == S_SEND) && !frame_d[idx_d]);
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_done    = done_q;
  assign tx_error   = (state_q == S_ERR);
  assign err_code   = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned SET = 8;
  localparam int unsigned STO = 300;
  localparam int unsigned BTO = 200;
  localparam int unsigned H   = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, set_cnt = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (rst_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .err_code  (err_code),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_done)                  done_cnt <= done_cnt + 1;
      if (tx_error)                 err_cnt  <= err_cnt + 1;
      if (ps2_clk_oe && !ps2_dat_oe) inh_cnt <= inh_cnt + 1;
      if (ps2_clk_oe && ps2_dat_oe)  set_cnt <= set_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_rx;   // {stop, parity, data[7:0]} as the device samples it
  } vec_t;

  vec_t tbl[4];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device BFM: waits for the host to release clk, then produces n clock
  // pulses, sampling dat just before each rising edge; pulls dat low for the
  // 11th pulse when ack is set.
  task automatic dev_run(input logic ack, input int n, output logic [9:0] rx, output int edges);
    int t;
    rx = '0;
    edges = 0;
    t = 0;
    while (!ps2_clk_oe && t < 3000) begin cyc(1); t++; end
    while (ps2_clk_oe && t < 3000) begin cyc(1); t++; end
    if (t >= 3000) begin
      checks++;
      failures++;
      $display("FAIL dev_wait_release: clk_oe=%0b after %0d cycles, want release", ps2_clk_oe, t);
      return;
    end
    cyc(10);
    for (int k = 1; k <= n; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        cyc(2);
      end
      dev_clk_low = 1'b1;
      edges++;
      cyc(H);
      if (k <= 10) rx[k-1] = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (k == 11) begin
        cyc(2);
        dev_dat_low = 1'b0;
      end
      cyc(H);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!tx_ready && t < 1000) begin cyc(1); t++; end
    chk("wait_ready", tx_ready, 1'b1);
    cyc(3);
  endtask

  initial begin
    logic [9:0] rx, rx2;
    logic [9:0] rx3[3];
    logic [7:0] list[3];
    int e, e2, d0, e0, i0, s0, n, ready_bad;

    tbl[0] = '{8'hED, 10'h3ED};
    tbl[1] = '{8'h00, 10'h300};
    tbl[2] = '{8'hFF, 10'h3FF};
    tbl[3] = '{8'h01, 10'h201};

    // Reset state
    cyc(3);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_error", tx_error, 1'b0);
    chk("rst_code", err_code, 2'b00);
    chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    rst_n = 1'b1;
    cyc(5);

    // Normal frames with device ack
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; s0 = set_cnt;
      accept(tbl[v].data);
      chk("tbl_busy", tx_busy, 1'b1);
      dev_run(1'b1, 11, rx, e);
      wait_ready();
      chk("tbl_bits", rx, tbl[v].exp_rx);
      chk("tbl_edges", e, 11);
      chk("tbl_done", done_cnt - d0, 1);
      chk("tbl_err", err_cnt - e0, 0);
      chk("tbl_code", err_code, 2'b00);
      chk("tbl_inhibit_len", inh_cnt - i0, INH);
      chk("tbl_setup_len", set_cnt - s0, SET);
    end

    // Device never clocks after release
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h12);
    n = 0;
    while (ps2_clk_oe && n < 2000) begin cyc(1); n++; end
    n = 0;
    while (!tx_error && n < 1000) begin cyc(1); n++; end
    chk("start_tmo_lat_lo", n >= STO, 1'b1);
    chk("start_tmo_lat_hi", n <= STO + 4, 1'b1);
    chk("start_tmo_code", err_code, 2'b01);
    cyc(1);
    chk("start_tmo_pulse_len", tx_error, 1'b0);
    chk("start_tmo_ready", tx_ready, 1'b1);
    chk("start_tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    cyc(3);
    chk("start_tmo_err_cnt", err_cnt - e0, 1);
    chk("start_tmo_done_cnt", done_cnt - d0, 0);

    // Device stalls mid-frame
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h5A);
    chk("bit_tmo_code_cleared", err_code, 2'b00);
    dev_run(1'b1, 3, rx, e);
`ifdef PS2_TX_RETRY_EN
    dev_run(1'b1, 3, rx, e);
`endif
    wait_ready();
    chk("bit_tmo_code", err_code, 2'b10);
    chk("bit_tmo_err_cnt", err_cnt - e0, 1);
    chk("bit_tmo_done_cnt", done_cnt - d0, 0);

    // Device never acks
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    accept(8'h55);
    dev_run(1'b0, 11, rx, e);
`ifdef PS2_TX_RETRY_EN
    dev_run(1'b0, 11, rx2, e2);
    wait_ready();
    chk("nack_retry_bits", rx2, 10'h355);
    chk("nack_inhibit_twice", inh_cnt - i0, 2 * INH);
`else
    wait_ready();
    chk("nack_inhibit_once", inh_cnt - i0, INH);
`endif
    chk("nack_bits", rx, 10'h355);
    chk("nack_code", err_code, 2'b11);
    chk("nack_err_cnt", err_cnt - e0, 1);
    chk("nack_done_cnt", done_cnt - d0, 0);
    cyc(10);
    chk("nack_code_held", err_code, 2'b11);

`ifdef PS2_TX_RETRY_EN
    d0 = done_cnt; e0 = err_cnt;
    accept(8'h55);
    dev_run(1'b0, 11, rx, e);
    dev_run(1'b1, 11, rx2, e2);
    wait_ready();
    chk("retry_ack_bits", rx2, 10'h355);
    chk("retry_ack_done", done_cnt - d0, 1);
    chk("retry_ack_err", err_cnt - e0, 0);
    chk("retry_ack_code", err_code, 2'b00);
`endif

    // Reset while data bit 4 of 0xED (a 0) is on the line
    accept(8'hED);
    dev_run(1'b1, 4, rx, e);
    dev_clk_low = 1'b1;
    cyc(5);
    chk("rst_mid_pre_dat_oe", ps2_dat_oe, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_mid_pulses", {tx_done, tx_error}, 2'b00);
    chk("rst_mid_ready", tx_ready, 1'b1);
    cyc(3);
    dev_clk_low = 1'b0;
    rst_n = 1'b1;
    cyc(20);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_err", err_cnt - e0, 0);
    chk("rst_mid_code", err_code, 2'b00);
    accept(8'hFF);
    dev_run(1'b1, 11, rx, e);
    wait_ready();
    chk("rst_after_bits", rx, 10'h3FF);
    chk("rst_after_done", done_cnt - d0, 1);
    chk("rst_after_err", err_cnt - e0, 0);

    // tx_valid held across three frames, tx_data changing
    list[0] = 8'hA5; list[1] = 8'h3C; list[2] = 8'h07;
    d0 = done_cnt; e0 = err_cnt;
    ready_bad = 0;
    fork
      begin
        int k, t;
        k = 0; t = 0;
        while (k <= 3 && t < 5000) begin
          @(negedge clk);
          t++;
          if (tx_ready) begin
            if (k >= 1 && !tx_done) ready_bad++;
            if (k < 3) begin
              tx_data  = list[k];
              tx_valid = 1'b1;
            end else begin
              tx_valid = 1'b0;
            end
            k++;
          end else begin
            tx_data = 8'($urandom);
          end
        end
        tx_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 3; f++) dev_run(1'b1, 11, rx3[f], e);
      end
    join
    cyc(5);
    chk("b2b_frame0", rx3[0], 10'h3A5);
    chk("b2b_frame1", rx3[1], 10'h33C);
    chk("b2b_frame2", rx3[2], 10'h207);
    chk("b2b_done", done_cnt - d0, 3);
    chk("b2b_err", err_cnt - e0, 0);
    chk("b2b_ready_mid_frame", ready_bad, 0);
    chk("b2b_idle", tx_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
